x2050_psw_store: RTL and testbench

- Old-PSW store sequencer for the 2050 interrupt path.
- On an interrupt it snapshots the current PSW fields and writes the 64-bit old PSW to its fixed low-storage doubleword. The fields include the instruction length code (psw<32.33>) held by the ILC register.
- Writes go out as two 32-bit storage writes over a req/ack handshake.
- It consumes the ILC the decode side produces. It sits between interrupt priority logic and the main-storage port.

---
 rtl/x2050_pkg.sv | 47 ++++
 rtl/x2050_psw_pack.sv | 25 ++
 rtl/x2050_psw_store.sv | 144 ++++++++++++++
 tb/tb_x2050_psw_store.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/x2050_pkg.sv
// rtl/x2050_pkg.sv - shared interrupt class codes, old-PSW bases, field widths and FSM encoding
package x2050_pkg;

  localparam int SYSMASK_W = 8;
  localparam int KEY_W     = 4;
  localparam int AMWP_W    = 4;
  localparam int CODE_W    = 16;
  localparam int ILC_W     = 2;
  localparam int CC_W      = 2;
  localparam int PMASK_W   = 4;
  localparam int IC_W      = 24;

  localparam logic [2:0] CLS_EXT = 3'd0;
  localparam logic [2:0] CLS_SVC = 3'd1;
  localparam logic [2:0] CLS_PGM = 3'd2;
  localparam logic [2:0] CLS_MCK = 3'd3;
  localparam logic [2:0] CLS_IO  = 3'd4;

  localparam logic [7:0] BASE_EXT = 8'h18;
  localparam logic [7:0] BASE_SVC = 8'h20;
  localparam logic [7:0] BASE_PGM = 8'h28;
  localparam logic [7:0] BASE_MCK = 8'h30;
  localparam logic [7:0] BASE_IO  = 8'h38;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_W0   = 2'd1,
    ST_W1   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic class_valid(input logic [2:0] cls);
    return (cls <= CLS_IO);
  endfunction

  function automatic logic [7:0] class_base(input logic [2:0] cls);
    case (cls)
      CLS_EXT: return BASE_EXT;
      CLS_SVC: return BASE_SVC;
      CLS_PGM: return BASE_PGM;
      CLS_MCK: return BASE_MCK;
      CLS_IO:  return BASE_IO;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/x2050_psw_pack.sv
// rtl/x2050_psw_pack.sv - packs PSW fields into the two 32-bit storage words
module x2050_psw_pack
  import x2050_pkg::*;
(
  input  logic [2:0]           i_class,
  input  logic [SYSMASK_W-1:0] i_sysmask,
  input  logic [KEY_W-1:0]     i_key,
  input  logic [AMWP_W-1:0]    i_amwp,
  input  logic [CODE_W-1:0]    i_int_code,
  input  logic [ILC_W-1:0]     i_ilc,
  input  logic [CC_W-1:0]      i_cc,
  input  logic [PMASK_W-1:0]   i_pmask,
  input  logic [IC_W-1:0]      i_ic,
  output logic [31:0]          o_word0,
  output logic [31:0]          o_word1
);

  logic [ILC_W-1:0] w_ilc;

  // Only SVC and program interrupts report a meaningful instruction length.
  assign w_ilc   = ((i_class == CLS_SVC) || (i_class == CLS_PGM)) ? i_ilc : '0;
  assign o_word0 = {i_sysmask, i_key, i_amwp, i_int_code};
  assign o_word1 = {w_ilc, i_cc, i_pmask, i_ic};

endmodule

// File: rtl/x2050_psw_store.sv
// rtl/x2050_psw_store.sv - old-PSW store sequencer: snapshot PSW, write two words over req/ack
module x2050_psw_store
  import x2050_pkg::*;
#(
  parameter int AW = 24
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [2:0]           i_class,
  input  logic [SYSMASK_W-1:0] i_sysmask,
  input  logic [KEY_W-1:0]     i_key,
  input  logic [AMWP_W-1:0]    i_amwp,
  input  logic [CODE_W-1:0]    i_int_code,
  input  logic [ILC_W-1:0]     i_ilc,
  input  logic [CC_W-1:0]      i_cc,
  input  logic [PMASK_W-1:0]   i_pmask,
  input  logic [IC_W-1:0]      i_ic,
  output logic                 o_req,
  output logic [AW-1:0]        o_addr,
  output logic [31:0]          o_data,
  input  logic                 i_ack,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2:0]           r_class;
  logic [SYSMASK_W-1:0] r_sysmask;
  logic [KEY_W-1:0]     r_key;
  logic [AMWP_W-1:0]    r_amwp;
  logic [CODE_W-1:0]    r_int_code;
  logic [ILC_W-1:0]     r_ilc;
  logic [CC_W-1:0]      r_cc;
  logic [PMASK_W-1:0]   r_pmask;
  logic [IC_W-1:0]      r_ic;
  logic [AW-1:0]        r_base;
  logic                 r_err;
  logic                 w_accept;
  logic                 w_reject;
  logic [31:0]          w_word0;
  logic [31:0]          w_word1;
  logic [AW-1:0]        w_addr1;

  assign w_accept = (r_state == ST_IDLE) && i_start && class_valid(i_class);
  assign w_reject = (r_state == ST_IDLE) && i_start && !class_valid(i_class);
  assign w_addr1  = r_base + AW'(4);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Snapshot is taken only on an accepted start so later input changes cannot leak in.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_class    <= '0;
      r_sysmask  <= '0;
      r_key      <= '0;
      r_amwp     <= '0;
      r_int_code <= '0;
      r_ilc      <= '0;
      r_cc       <= '0;
      r_pmask    <= '0;
      r_ic       <= '0;
      r_base     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_class    <= i_class;
        r_sysmask  <= i_sysmask;
        r_key      <= i_key;
        r_amwp     <= i_amwp;
        r_int_code <= i_int_code;
        r_ilc      <= i_ilc;
        r_cc       <= i_cc;
        r_pmask    <= i_pmask;
        r_ic       <= i_ic;
        r_base     <= AW'(class_base(i_class));
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_W0;
      ST_W0:   if (i_ack) w_state_nxt = ST_W1;
      ST_W1:   if (i_ack) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  x2050_psw_pack u_pack (
    .i_class    (r_class),
    .i_sysmask  (r_sysmask),
    .i_key      (r_key),
    .i_amwp     (r_amwp),
    .i_int_code (r_int_code),
    .i_ilc      (r_ilc),
    .i_cc       (r_cc),
    .i_pmask    (r_pmask),
    .i_ic       (r_ic),
    .o_word0    (w_word0),
    .o_word1    (w_word1)
  );

  always_comb begin
    o_req  = 1'b0;
    o_addr = '0;
    o_data = '0;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      ST_W0: begin
        o_req  = 1'b1;
        o_addr = r_base;
        o_data = w_word0;
        o_busy = 1'b1;
      end
      ST_W1: begin
        o_req  = 1'b1;
        o_addr = w_addr1;
        o_data = w_word1;
        o_busy = 1'b1;
      end
      ST_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_err = r_err;

endmodule

// File: tb/tb_x2050_psw_store.sv
// tb/tb_x2050_psw_store.sv - randomized and directed checks of x2050_psw_store against a queue model
module tb_x2050_psw_store;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_ack;
  logic [2:0]  i_class;
  logic [7:0]  i_sysmask;
  logic [3:0]  i_key, i_amwp, i_pmask;
  logic [15:0] i_int_code;
  logic [1:0]  i_ilc, i_cc;
  logic [23:0] i_ic;
  logic        o_req, o_busy, o_done, o_err;
  logic [23:0] o_addr;
  logic [31:0] o_data;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;
  int done_cnt = 0;
  logic [23:0] log_addr[$];
  logic [31:0] log_data[$];

  always #5 clk = ~clk;

  x2050_psw_store #(.AW(24)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_class(i_class),
    .i_sysmask(i_sysmask), .i_key(i_key), .i_amwp(i_amwp), .i_int_code(i_int_code),
    .i_ilc(i_ilc), .i_cc(i_cc), .i_pmask(i_pmask), .i_ic(i_ic),
    .o_req(o_req), .o_addr(o_addr), .o_data(o_data), .i_ack(i_ack),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: pending words as a queue of {addr,data}; a sequence is busy while words remain or done shows.
  logic [55:0] m_q[$];
  bit m_done = 0;
  bit m_err = 0;

  always @(posedge clk) begin
    bit nd, ne;
    longint base;
    longint w0, w1;
    int ilc_eff;
    nd = 0;
    ne = 0;
    if (i_reset) begin
      m_q.delete();
    end else if (m_q.size() > 0) begin
      if (i_ack) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) nd = 1;
      end
    end else if (!m_done && i_start) begin
      if (i_class < 5) begin
        base = 24 + 8 * i_class;
        ilc_eff = (i_class == 1 || i_class == 2) ? i_ilc : 0;
        w0 = i_sysmask * 64'h1000000 + i_key * 64'h100000 + i_amwp * 64'h10000 + i_int_code;
        w1 = ilc_eff * 64'h40000000 + i_cc * 64'h10000000 + i_pmask * 64'h1000000 + i_ic;
        m_q.push_back({base[23:0], w0[31:0]});
        base = (base + 4) % 64'h1000000;
        m_q.push_back({base[23:0], w1[31:0]});
      end else begin
        ne = 1;
      end
    end
    m_done = nd;
    m_err = ne;
  end

  always @(negedge clk) begin
    logic [59:0] act, exp;
    if (mon_en) begin
      act = {o_req, o_busy, o_done, o_err, o_addr, o_data};
      if (m_q.size() > 0)
        exp = {1'b1, 1'b1, 1'b0, m_err, m_q[0]};
      else
        exp = {1'b0, m_done, m_done, m_err, 56'h0};
      chk("cycle", 64'(act), 64'(exp));
      if (o_req && i_ack) begin
        log_addr.push_back(o_addr);
        log_data.push_back(o_data);
      end
      if (o_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] c, input logic [7:0] sm, input logic [3:0] k,
                            input logic [3:0] am, input logic [15:0] code, input logic [1:0] ilc,
                            input logic [1:0] cc, input logic [3:0] pm, input logic [23:0] ic);
    i_class = c; i_sysmask = sm; i_key = k; i_amwp = am; i_int_code = code;
    i_ilc = ilc; i_cc = cc; i_pmask = pm; i_ic = ic;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    int d0;
    i_reset = 1'b1; i_start = 1'b0; i_ack = 1'b0;
    set_fields(3'd0, 8'h0, 4'h0, 4'h0, 16'h0, 2'b0, 2'b0, 4'h0, 24'h0);
    tick();
    mon_en = 1;
    tick();
    #3;
    chk("reset_outputs", {o_req, o_busy, o_done, o_err, o_addr, o_data}, 64'h0);
    i_reset = 1'b0;
    tick();

    // Program interrupt, ack held high
    set_fields(3'd2, 8'hFF, 4'h3, 4'h5, 16'h0006, 2'b10, 2'b01, 4'hC, 24'h001234);
    i_ack = 1'b1;
    log_addr.delete(); log_data.delete();
    d0 = done_cnt;
    pulse_start();
    chk("pgm_req_t1", {o_req, o_done}, 2'b10);
    tick();
    chk("pgm_done_t2", o_done, 1'b0);
    tick();
    chk("pgm_done_t3", o_done, 1'b1);
    i_ack = 1'b0;
    tick();
    chk("pgm_nwords", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("pgm_w0", {log_addr[0], log_data[0]}, {24'd40, 32'hFF350006});
      chk("pgm_w1", {log_addr[1], log_data[1]}, {24'd44, 32'h9C001234});
    end
    chk("pgm_one_done", done_cnt - d0, 1);

    // External interrupt: ILC forced to zero
    set_fields(3'd0, 8'hA5, 4'h7, 4'h2, 16'h0040, 2'b11, 2'b00, 4'h0, 24'h000100);
    i_ack = 1'b1;
    log_addr.delete(); log_data.delete();
    pulse_start();
    tick(); tick(); i_ack = 1'b0; tick();
    chk("ext_nwords", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("ext_w0", {log_addr[0], log_data[0]}, {24'd24, 32'hA5720040});
      chk("ext_w1", {log_addr[1], log_data[1]}, {24'd28, 32'h00000100});
    end

    // SVC with ack stalls on each word
    set_fields(3'd1, 8'h12, 4'h4, 4'h1, 16'h00AB, 2'b01, 2'b11, 4'h9, 24'hABCDEF);
    i_ack = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      chk("stall_w0", {o_req, o_busy, o_addr, o_data}, {2'b11, 24'd32, 32'h124100AB});
      tick();
    end
    i_ack = 1'b1; tick(); i_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_w1", {o_req, o_busy, o_addr, o_data}, {2'b11, 24'd36, 32'h79ABCDEF});
      tick();
    end
    i_ack = 1'b1; tick(); i_ack = 1'b0;
    chk("stall_done", {o_busy, o_done}, 2'b11);
    tick();

    // Snapshot holds while inputs change; start in W0 ignored
    set_fields(3'd2, 8'h01, 4'h2, 4'h3, 16'h0004, 2'b01, 2'b10, 4'h5, 24'h000800);
    log_addr.delete(); log_data.delete();
    d0 = done_cnt;
    pulse_start();
    i_ilc = 2'b11; i_ic = 24'hFFFFFF; i_class = 3'd4;
    pulse_start();
    i_ack = 1'b1; tick(); tick(); i_ack = 1'b0;
    tick(); tick(); tick();
    chk("snap_nwords", log_addr.size(), 2);
    if (log_addr.size() == 2)
      chk("snap_w1", {log_addr[1], log_data[1]}, {24'd44, 32'h65000800});
    chk("snap_one_done", done_cnt - d0, 1);

    // Invalid class, then valid start on the following cycle
    i_class = 3'd6;
    pulse_start();
    chk("inv_err", {o_err, o_req, o_busy}, 3'b100);
    i_class = 3'd4;
    pulse_start();
    chk("inv_then_valid", {o_err, o_req, o_addr}, {2'b01, 24'd56});
    i_ack = 1'b1; tick(); tick(); i_ack = 1'b0; tick();

    // Reset while stalled in W1
    d0 = done_cnt;
    i_class = 3'd3;
    pulse_start();
    i_ack = 1'b1; tick(); i_ack = 1'b0;
    tick(); tick();
    chk("rst_in_w1", {o_req, o_addr}, {1'b1, 24'd52});
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    chk("rst_drop", {o_req, o_busy, o_done}, 3'b000);
    tick(); tick();
    chk("rst_no_done", done_cnt - d0, 0);
    pulse_start();
    chk("rst_restart_w0", {o_req, o_addr}, {1'b1, 24'd48});
    i_ack = 1'b1; tick(); tick(); i_ack = 1'b0; tick();

    // Randomized traffic; the per-cycle comparison checks everything
    for (int n = 0; n < 1500; n++) begin
      i_start = ($urandom_range(0, 3) == 0);
      i_class = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      i_sysmask = 8'($urandom); i_key = 4'($urandom); i_amwp = 4'($urandom);
      i_int_code = 16'($urandom); i_ilc = 2'($urandom); i_cc = 2'($urandom);
      i_pmask = 4'($urandom); i_ic = 24'($urandom);
      i_ack = ($urandom_range(0, 2) != 0);
      i_reset = ($urandom_range(0, 79) == 0);
      tick();
    end
    i_start = 1'b0; i_reset = 1'b0; i_ack = 1'b1;
    tick(); tick(); tick(); tick();
    chk("final_idle", {o_req, o_busy}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
